branch_predict_unit: RTL

Parametrised branch resolution and dynamic prediction block for the RISC-V pipeline. It resolves conditional branches in EX, using the same six compare types as the existing branch decision logic. It also holds a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters, giving IF a same-cycle taken/target prediction. EX results train the tables on the next clock edge, and EX raises a mispredict/recover request to the hazard unit. It replaces the static predict-not-taken path between IF and EX.

---
 rtl/branch_predict_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
// Branch resolution for EX plus a direct-mapped BTB with 2-bit direction counters.
// IF gets a same-cycle prediction; EX trains the table and raises mispredict/recover.
module branch_predict_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   PCF,
  output logic              PredTakenF,
  output logic [XLEN-1:0]   PredTargetF,
  input  logic              UpdateEnE,
  input  logic [2:0]        BranchTypeE,
  input  logic [XLEN-1:0]   Operand1E,
  input  logic [XLEN-1:0]   Operand2E,
  input  logic [XLEN-1:0]   PCE,
  input  logic [XLEN-1:0]   BrTargetE,
  input  logic              PredTakenE,
  input  logic [XLEN-1:0]   PredTargetE,
  output logic              BranchE,
  output logic              MispredictE,
  output logic [XLEN-1:0]   RecoverPCE,
  output logic [STAT_W-1:0] BranchCnt,
  output logic [STAT_W-1:0] MissCnt
);

  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned TAG_W   = XLEN - IDX_W - 2;

  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BLTU = 3'd4;
  localparam logic [2:0] BR_BGE  = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;

  logic              valid_q  [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [XLEN-1:0]   target_q [ENTRIES];

  logic [IDX_W-1:0]  idx_f;
  logic [TAG_W-1:0]  tag_f;
  logic [IDX_W-1:0]  idx_e;
  logic [TAG_W-1:0]  tag_e;
  logic              hit_f;
  logic              hit_e;
  logic              br;
  logic              eq;
  logic              lt_s;
  logic              lt_u;
  logic              unused_bits;

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[XLEN-1:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[XLEN-1:IDX_W+2];
  assign unused_bits = ^{PCF[1:0], PCE[1:0]};

  // IF lookup: asynchronous read, so a same-edge write is not yet visible
  assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign PredTakenF  = hit_f && ctr_q[idx_f][1];
  assign PredTargetF = PredTakenF ? target_q[idx_f] : '0;

  assign eq   = (Operand1E == Operand2E);
  assign lt_s = ($signed(Operand1E) < $signed(Operand2E));
  assign lt_u = (Operand1E < Operand2E);

  always_comb begin
    BranchE = 1'b0;
    br      = 1'b0;
    case (BranchTypeE)
      BR_BEQ:  begin BranchE = eq;    br = UpdateEnE; end
      BR_BNE:  begin BranchE = !eq;   br = UpdateEnE; end
      BR_BLT:  begin BranchE = lt_s;  br = UpdateEnE; end
      BR_BLTU: begin BranchE = lt_u;  br = UpdateEnE; end
      BR_BGE:  begin BranchE = !lt_s; br = UpdateEnE; end
      BR_BGEU: begin BranchE = !lt_u; br = UpdateEnE; end
      default: begin BranchE = 1'b0;  br = 1'b0;      end
    endcase
  end

  assign MispredictE = br && ((BranchE != PredTakenE) ||
                              (BranchE && (PredTargetE != BrTargetE)));
  assign RecoverPCE  = BranchE ? BrTargetE : (PCE + XLEN'(4));

  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  // Direction state: only valid and ctr are reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (br) begin
      if (hit_e) begin
        if (BranchE) begin
          if (ctr_q[idx_e] != 2'b11) ctr_q[idx_e] <= ctr_q[idx_e] + 2'd1;
        end else if (ctr_q[idx_e] != 2'b00) begin
          ctr_q[idx_e] <= ctr_q[idx_e] - 2'd1;
        end
      end else if (BranchE) begin
        valid_q[idx_e] <= 1'b1;
        ctr_q[idx_e]   <= 2'b10;
      end
    end
  end

  // Any taken resolution refreshes tag/target (unchanged tag on a hit)
  always_ff @(posedge clk) begin
    if (!rst && br && BranchE) begin
      tag_q[idx_e]    <= tag_e;
      target_q[idx_e] <= BrTargetE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      BranchCnt <= '0;
      MissCnt   <= '0;
    end else if (br) begin
      if (BranchCnt != {STAT_W{1'b1}}) BranchCnt <= BranchCnt + STAT_W'(1);
      if (MispredictE && (MissCnt != {STAT_W{1'b1}})) MissCnt <= MissCnt + STAT_W'(1);
    end
  end

endmodule
